// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: multi-item vending controller; `define VEND_SALES_LOG_EN adds revenue and sold_count outputs.
module vend_ctrl_multi #(
    parameter int NUM_ITEMS  = 6,
    parameter int TYPE_W     = 3,
    parameter int MONEY_W    = 7,
    parameter int QTY_W      = 4,
    parameter int PRICE_BASE = 3,
    parameter int PRICE_STEP = 2,
    parameter int INIT_STOCK = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [TYPE_W-1:0]  supply_type,
    input  logic [MONEY_W-1:0] customer_money,
    input  logic [QTY_W-1:0]   customer_amount,
    input  logic [QTY_W-1:0]   amount_supply_to_add,
    output logic               dispense_pulse,
    output logic [TYPE_W-1:0]  dispense_type,
    output logic               done_valid,
    output logic [MONEY_W-1:0] change,
    output logic [6:0]         error,
    output logic               red_light
`ifdef VEND_SALES_LOG_EN
    ,
    output logic [15:0]        revenue,
    output logic [15:0]        sold_count
`endif
);
    localparam int CW = MONEY_W + QTY_W;
    typedef enum logic [2:0] {IDLE, CALC, CHECK, DISPENSE, RESTOCK, DONE} state_t;
    state_t state, state_n;
    logic [TYPE_W-1:0]  type_q, idx;
    logic [MONEY_W-1:0] money_q;
    logic [QTY_W-1:0]   qty_q, add_q, cnt_q, cur_stock;
    logic [CW-1:0]      cost_q;
    logic [QTY_W-1:0]   stock [NUM_ITEMS];
    logic [QTY_W:0]     sum;
    logic [6:0]         chk_err;
    logic               accept, type_ok, ovf;
    assign accept    = req_valid && req_ready;
    assign type_ok   = 32'(type_q) < NUM_ITEMS;
    assign idx       = type_ok ? type_q : '0;
    assign cur_stock = stock[idx];
    assign sum       = {1'b0, cur_stock} + {1'b0, add_q};
    assign ovf       = type_ok && sum[QTY_W];
    // An invalid type never indexes price/stock, so the money and stock checks are masked
    assign chk_err   = {3'b000, qty_q == '0, type_ok && (qty_q > cur_stock),
                        type_ok && (cost_q > CW'(money_q)), !type_ok};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end
    always_comb begin
        state_n        = state;
        req_ready      = state == IDLE;
        dispense_pulse = state == DISPENSE;
        dispense_type  = state == DISPENSE ? type_q : '0;
        done_valid     = state == DONE;
        case (state)
            IDLE:     if (accept) state_n = mode == 2'd1 ? CALC : mode == 2'd2 ? RESTOCK : mode == 2'd3 ? DONE : IDLE;
            CALC:     state_n = CHECK;
            CHECK:    state_n = |chk_err ? DONE : DISPENSE;
            DISPENSE: state_n = cnt_q == QTY_W'(1) ? DONE : DISPENSE;
            RESTOCK:  state_n = DONE;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= QTY_W'(INIT_STOCK);
            type_q    <= '0;
            money_q   <= '0;
            qty_q     <= '0;
            add_q     <= '0;
            cnt_q     <= '0;
            cost_q    <= '0;
            change    <= '0;
            error     <= '0;
            red_light <= 1'b0;
        end else begin
            if (accept) begin
                type_q  <= supply_type;
                money_q <= customer_money;
                qty_q   <= customer_amount;
                cnt_q   <= customer_amount;
                add_q   <= amount_supply_to_add;
                if (mode == 2'd3) begin
                    error     <= 7'b0100000;
                    change    <= '0;
                    red_light <= 1'b1;
                end
            end
            if (state == CALC)
                cost_q <= type_ok ? (CW'(PRICE_BASE) + CW'(type_q) * CW'(PRICE_STEP)) * CW'(qty_q) : '0;
            if (state == CHECK) begin
                error     <= chk_err;
                red_light <= |chk_err;
                change    <= |chk_err ? money_q : money_q - cost_q[MONEY_W-1:0];
            end
            if (state == DISPENSE) begin
                stock[idx] <= cur_stock - QTY_W'(1);
                cnt_q      <= cnt_q - QTY_W'(1);
            end
            if (state == RESTOCK) begin
                error     <= {2'b00, ovf, 3'b000, !type_ok};
                red_light <= ovf || !type_ok;
                change    <= '0;
                if (type_ok && !ovf) stock[idx] <= sum[QTY_W-1:0];
            end
        end
    end
`ifdef VEND_SALES_LOG_EN
    logic [16:0] rev_sum;
    assign rev_sum = {1'b0, revenue} + 17'(cost_q);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            revenue    <= '0;
            sold_count <= '0;
        end else begin
            if (state == CHECK && !(|chk_err)) revenue <= rev_sum[16] ? 16'hFFFF : rev_sum[15:0];
            if (state == DISPENSE && sold_count != 16'hFFFF) sold_count <= sold_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_vend_ctrl_multi.sv
// tb_vend_ctrl_multi: scoreboard bench for vend_ctrl_multi with a behavioural stock/price model.
module tb_vend_ctrl_multi;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [1:0] mode = '0;
    logic       req_valid = 1'b0, req_ready;
    logic [2:0] supply_type = '0, dispense_type;
    logic [6:0] customer_money = '0, change, error;
    logic [3:0] customer_amount = '0, amount_supply_to_add = '0;
    logic       dispense_pulse, done_valid, red_light;
    typedef struct {
        logic [6:0] err;
        logic [6:0] chg;
        bit         chk_chg;
        int         pulses;
        logic [2:0] typ;
        int         done_cyc;
    } exp_t;
    exp_t sb[$];
    int mstock[6];
    int cyc = 0, pulses = 0, checks = 0, failures = 0;
    vend_ctrl_multi dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .req_valid(req_valid), .req_ready(req_ready),
        .supply_type(supply_type), .customer_money(customer_money), .customer_amount(customer_amount),
        .amount_supply_to_add(amount_supply_to_add), .dispense_pulse(dispense_pulse),
        .dispense_type(dispense_type), .done_valid(done_valid), .change(change), .error(error),
        .red_light(red_light)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, int'(req_ready), 1);
        chk({tag, "_pulse"}, int'(dispense_pulse), 0);
        chk({tag, "_dtype"}, int'(dispense_type), 0);
        chk({tag, "_done"}, int'(done_valid), 0);
        chk({tag, "_change"}, int'(change), 0);
        chk({tag, "_error"}, int'(error), 0);
        chk({tag, "_red"}, int'(red_light), 0);
    endtask
    always @(negedge clk) begin
        if (rst_n) begin
            if (dispense_pulse) begin
                if (sb.size() == 0) chk("stray_pulse", 1, 0);
                else begin
                    chk("dispense_type", int'(dispense_type), int'(sb[0].typ));
                    pulses++;
                end
            end
            if (done_valid) begin
                if (sb.size() == 0) chk("stray_done", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("error", int'(error), int'(e.err));
                    if (e.chk_chg) chk("change", int'(change), int'(e.chg));
                    chk("red_light", int'(red_light), int'(|e.err));
                    chk("pulse_count", pulses, e.pulses);
                    chk("done_cycle", cyc, e.done_cyc);
                    pulses = 0;
                end
            end
        end
    end
    task automatic do_req(input int md, input int t, input int m, input int q, input int a);
        exp_t e;
        int cost, lat;
        @(negedge clk);
        for (int i = 0; i < 200 && !req_ready; i++) @(negedge clk);
        if (!req_ready) begin
            chk("req_ready_timeout", 0, 1);
            return;
        end
        e.typ = 3'(t); e.err = '0; e.chg = '0; e.chk_chg = 1; e.pulses = 0; lat = 0;
        if (md == 1) begin
            cost = (t < 6) ? (3 + 2 * t) * q : 0;
            if (t >= 6) e.err[0] = 1'b1;
            else begin
                if (cost > m) e.err[1] = 1'b1;
                if (q > mstock[t]) e.err[2] = 1'b1;
            end
            if (q == 0) e.err[3] = 1'b1;
            if (e.err == 0) begin
                e.chg = 7'(m - cost);
                e.pulses = q;
                mstock[t] -= q;
                lat = 3 + q;
            end else begin
                e.chg = 7'(m);
                lat = 3;
            end
        end else if (md == 2) begin
            if (mstock[t] + a > 15) e.err[4] = 1'b1;
            else mstock[t] += a;
            lat = 2;
        end else if (md == 3) begin
            e.err[5] = 1'b1;
            e.chk_chg = 0;
            lat = 1;
        end
        mode = 2'(md); supply_type = 3'(t); customer_money = 7'(m);
        customer_amount = 4'(q); amount_supply_to_add = 4'(a);
        req_valid = 1'b1;
        e.done_cyc = cyc + lat;
        if (md != 0) sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        mode = 2'($urandom); supply_type = 3'($urandom); customer_money = 7'($urandom);
        customer_amount = 4'($urandom); amount_supply_to_add = 4'($urandom);
    endtask
    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask
    initial begin
        for (int i = 0; i < 6; i++) mstock[i] = 5;
        #3 chk_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        do_req(1, 0, 20, 2, 0);
        do_req(1, 5, 1, 4, 0);
        do_req(1, 1, 60, 6, 0);
        do_req(1, 1, 10, 0, 0);
        do_req(1, 6, 15, 3, 0);
        do_req(3, 0, 0, 0, 0);
        do_req(2, 2, 0, 0, 12);
        do_req(2, 2, 0, 0, 10);
        do_req(0, 3, 9, 2, 0);
        do_req(1, 0, 20, 3, 0);
        do_req(1, 0, 20, 1, 0);
        drain();
        for (int n = 0; n < 200; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) do_req(0, $urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 6), 0);
            else if (r <= 6) do_req(1, $urandom_range(0, 6), $urandom_range(0, 127), $urandom_range(0, 6), 0);
            else if (r <= 8) do_req(2, $urandom_range(0, 5), 0, 0, $urandom_range(0, 8));
            else do_req(3, 0, 0, 0, 0);
        end
        drain();
        do_req(2, 0, 0, 0, 15);
        drain();
        do_req(1, 0, 20, 3, 0);
        for (int i = 0; i < 50 && !dispense_pulse; i++) @(negedge clk);
        chk("reset_test_first_pulse", int'(dispense_pulse), 1);
        #2 rst_n = 1'b0;
        sb.delete();
        pulses = 0;
        for (int i = 0; i < 6; i++) mstock[i] = 5;
        #1 chk_reset_outputs("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", int'(req_ready), 1);
        do_req(1, 0, 100, 5, 0);
        do_req(1, 0, 100, 1, 0);
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
